mem_slave_sram: RTL
===================

// Module: mem_slave_sram
// PURPOSE
//  Slave (responder) end of the memory_bus protocol. On-chip word-organised SRAM with byte-lane writes and a
//  programmable fixed wait-state count. Serves one core master (fetch or data port) in sim and FPGA builds.
//  Stands in for the cache/memory hierarchy until that exists.
// PARAMETERS
//  ADDR_WIDTH   12   word-address bits used; depth = 2**ADDR_WIDTH words (default 16 KiB)
//  WAIT_CYCLES  1    extra cycles between request acceptance and ready; legal range 0..15
//  INIT_FILE    ""   if non-empty, $readmemh image loaded at time 0; otherwise contents are X
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  rst           in   1      synchronous, active-high reset
//  bus           --   --     memory_bus.slave modport; its members are listed below
//  bus.addr      in   30     word address [31:2]; only [ADDR_WIDTH+1:2] decoded, upper bits ignored (aliasing)
//  bus.dataD     in   32     write data
//  bus.byteSel   in   4      write byte enables; bit i -> dataD[8i+7:8i]
//  bus.read      in   1      read request
//  bus.write     in   1      write request
//  bus.dataQ     out  32     read data; registered
//  bus.ready     out  1      one-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE, ready=0, dataQ=0, wait counter=0. Memory array is not cleared.
//  FSM states: IDLE, WAIT, RESP.
//  - IDLE: on a posedge with (read|write)=1, latch the request. Latched fields are addr, dataD, byteSel
//    and the op; write wins if both read and write are high.
//    Next state is WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else RESP.
//  - WAIT: counter decrements each cycle. Leave for RESP on the edge where counter==0.
//    Bus inputs are ignored; only the latched copy is used.
//  - RESP: ready=1 for exactly this cycle. Unconditional next state is IDLE.
//  Array access happens on the edge entering RESP.
//  - Write: lanes with byteSel[i]=1 are updated; other lanes are preserved. byteSel=0000 is a no-op, still acked.
//    dataQ is unchanged on a write.
//  - Read: dataQ <= mem[addr] on that same edge, so dataQ is valid while ready=1.
//    dataQ then holds until the next read completes.
//  Latency: request first seen at edge N -> ready high during cycle N+1+WAIT_CYCLES.
//  Back-to-back accesses take a minimum of 2+WAIT_CYCLES cycles each.
//  Handshake: master holds read/write high until it samples ready=1, then drops or changes them in the next cycle.
//  - IDLE after RESP samples the bus fresh, so a held request is never double-served.
//  - Request dropped before ready: the access still completes as latched and ready still pulses.
//  Reset mid-operation: rst has priority on every edge.
//  - A write not yet committed (rst on the RESP-entry edge or earlier) is discarded.
//  - No ready pulse is produced for an aborted access.
//  Read and write both high: treated as a write. dataQ is not updated.
// CONFIGURATION
//  MEM_SLAVE_PERF_EN defined: adds two 32-bit outputs, perf_rd_cnt and perf_wr_cnt.
//  - Each counter increments on the edge entering RESP for its op type and wraps 0xFFFFFFFF -> 0.
//  - rst clears both counters.
//  Not defined: the ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//  1 WAIT_CYCLES=1: write addr 0x10, dataD=0xDEADBEEF, byteSel=1111, then read 0x10.
//    -> ready 2 cycles after each request edge; dataQ=0xDEADBEEF.
//  2 Byte lanes: mem[0x20]=0x11223344; write dataD=0xAABBCCDD with byteSel=0101; read back -> 0x11BB33DD.
//  3 WAIT_CYCLES=0: hold read continuously to addresses 0,1,2.
//    -> ready pulses every 2 cycles; each address is served exactly once; dataQ matches the model.
//  4 Assert rst on the edge entering RESP of a write 0x55555555 to addr 0x30 (old value 0x0).
//    -> no ready pulse; a later read returns 0x0.
//  5 read=write=1, byteSel=1111, dataD=0x12345678, addr 0x40 -> write performed; dataQ unchanged.
//    A later read of 0x40 returns 0x12345678.
//  6 MEM_SLAVE_PERF_EN: 3 reads + 2 writes -> perf_rd_cnt=3, perf_wr_cnt=2; after rst both are 0.

Source files
------------

// File: rtl/mem_slave_sram_if.sv
// memory_bus: single-master request/ready memory interface.
// The master holds read/write until it samples ready, then drops or changes them.
interface memory_bus;
    logic [29:0] addr;     // word address [31:2]
    logic [31:0] dataD;    // write data
    logic [3:0]  byteSel;  // write byte enables
    logic        read;
    logic        write;
    logic [31:0] dataQ;    // read data
    logic        ready;    // one-cycle completion pulse

    modport slave (
        input  addr, dataD, byteSel, read, write,
        output dataQ, ready
    );

    modport master (
        output addr, dataD, byteSel, read, write,
        input  dataQ, ready
    );
endinterface

// File: rtl/mem_slave_sram.sv
// mem_slave_sram: word-organised on-chip SRAM responder for memory_bus.
// Byte-lane writes and a fixed, parameterised wait-state count.
// Define MEM_SLAVE_PERF_EN to add the perf_rd_cnt / perf_wr_cnt completion counters.
module mem_slave_sram #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MEM_SLAVE_PERF_EN
    output logic [31:0] perf_rd_cnt,
    output logic [31:0] perf_wr_cnt,
`endif
    memory_bus.slave    bus
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  we_q, we_d;
    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;

    // Array access issued on the edge that enters StResp
    logic                  acc_en;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;

    logic [31:0] mem [Depth];

    // Upper word-address bits alias onto the decoded range
    generate
        if (ADDR_WIDTH < 30) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.addr[29:ADDR_WIDTH];
        end
    endgenerate

    // Next-state, request latching and array access decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        we_d      = we_q;
        acc_en    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;

        unique case (state_q)
            StIdle: begin
                if (bus.read || bus.write) begin
                    addr_d  = bus.addr[ADDR_WIDTH-1:0];
                    wdata_d = bus.dataD;
                    be_d    = bus.byteSel;
                    we_d    = bus.write;  // write wins over read
                    if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        // Zero wait states: access straight from the bus inputs
                        state_d   = StResp;
                        acc_en    = 1'b1;
                        acc_we    = bus.write;
                        acc_addr  = bus.addr[ADDR_WIDTH-1:0];
                        acc_wdata = bus.dataD;
                        acc_be    = bus.byteSel;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    acc_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StResp);
        rdata_d = (acc_en && !acc_we) ? mem[acc_addr] : rdata_q;
    end

`ifdef MEM_SLAVE_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;

    // Completion counters, wrap naturally at 2**32
    always_comb begin
        perf_rd_d = perf_rd_q;
        perf_wr_d = perf_wr_q;
        if (acc_en) begin
            if (acc_we) begin
                perf_wr_d = perf_wr_q + 32'd1;
            end else begin
                perf_rd_d = perf_rd_q + 32'd1;
            end
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_q <= 32'd0;
            perf_wr_q <= 32'd0;
        end else begin
            perf_rd_q <= perf_rd_d;
            perf_wr_q <= perf_wr_d;
        end
    end

    assign perf_rd_cnt = perf_rd_q;
    assign perf_wr_cnt = perf_wr_q;
`endif

    // FSM, latched request and registered outputs; reset has priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // Byte-lane array write; suppressed by reset so an aborted write never commits
    always_ff @(posedge clk) begin
        if (!rst && acc_en && acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.dataQ = rdata_q;
endmodule
